// File: rtl/usb_pkg.sv
// usb_pkg: shared USB receive/transmit types and constants
package usb_pkg;
  typedef enum logic [1:0] {NORMAL, DROP, ERROR} unstuff_state_t;
  localparam int USB_STUFF_RUN = 6;
endpackage

// File: rtl/usb_byte_assembler.sv
// usb_byte_assembler: LSB-first serial-to-byte shift register with completion pulse
module usb_byte_assembler (
  input  logic       clk,
  input  logic       RST,
  input  logic       clr,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out_byte,
  output logic       out_byte_valid
);
  logic [2:0] cnt;
  always_ff @(posedge clk) begin
    if (RST || clr) begin
      cnt            <= '0;
      out_byte       <= '0;
      out_byte_valid <= 1'b0;
    end else begin
      out_byte_valid <= bit_valid && cnt == 3'd7;
      if (bit_valid) begin
        out_byte <= {bit_in, out_byte[7:1]};
        cnt      <= cnt + 3'd1;
      end
    end
  end
endmodule

// File: rtl/usb_bit_unstuffer.sv
// usb_bit_unstuffer: removes the stuffed zero after RUN_LEN ones, flags stuffing violations.
// Optional byte assembly output enabled by USB_UNSTUFF_BYTE_EN.
module usb_bit_unstuffer
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       pkt_start,
  output logic       out_bit,
  output logic       out_valid,
  output logic       stuff_err,
  output logic       in_error
`ifdef USB_UNSTUFF_BYTE_EN
  ,
  output logic [7:0] out_byte,
  output logic       out_byte_valid
`endif
);
  unstuff_state_t state, eff_state;
  logic [CNT_W-1:0] ones_cnt, eff_cnt;
  // pkt_start restarts run tracking in the same cycle it arrives
  always_comb begin
    eff_state = pkt_start ? NORMAL : state;
    eff_cnt   = pkt_start ? '0 : ones_cnt;
  end
  assign in_error = state == ERROR;
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= NORMAL;
      ones_cnt  <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      stuff_err <= 1'b0;
      state     <= eff_state;
      ones_cnt  <= eff_cnt;
      if (in_valid) begin
        case (eff_state)
          NORMAL: begin
            out_valid <= 1'b1;
            out_bit   <= in_bit;
            ones_cnt  <= in_bit ? eff_cnt + CNT_W'(1) : '0;
            state     <= (in_bit && eff_cnt == CNT_W'(RUN_LEN - 1)) ? DROP : NORMAL;
          end
          DROP: begin
            ones_cnt  <= '0;
            stuff_err <= in_bit;
            state     <= in_bit ? ERROR : NORMAL;
          end
          default: ones_cnt <= '0;
        endcase
      end
    end
  end
`ifdef USB_UNSTUFF_BYTE_EN
  usb_byte_assembler u_asm (
    .clk            (clk),
    .RST            (RST),
    .clr            (pkt_start || stuff_err),
    .bit_in         (out_bit),
    .bit_valid      (out_valid),
    .out_byte       (out_byte),
    .out_byte_valid (out_byte_valid)
  );
`endif
endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// tb_usb_bit_unstuffer: directed self-checking bench for usb_bit_unstuffer
module tb_usb_bit_unstuffer;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic in_bit = 1'b0, in_valid = 1'b0, pkt_start = 1'b0;
  logic out_bit, out_valid, stuff_err, in_error;
  int n_checks = 0;
  int n_fail = 0;
`ifdef USB_UNSTUFF_BYTE_EN
  logic [7:0] out_byte;
  logic       out_byte_valid;
`endif

  usb_bit_unstuffer dut (
    .clk       (clk),
    .RST       (RST),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .pkt_start (pkt_start),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .stuff_err (stuff_err),
    .in_error  (in_error)
`ifdef USB_UNSTUFF_BYTE_EN
    ,
    .out_byte       (out_byte),
    .out_byte_valid (out_byte_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic b, input logic v, input logic p);
    in_bit = b;
    in_valid = v;
    pkt_start = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pkt_start = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({out_bit, out_valid, stuff_err, in_error} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset[%0d]: got bit/valid/err/in_error=%b, want 0000", i, {out_bit, out_valid, stuff_err, in_error});
      end
    end
    RST = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, out_bit} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_first_bit: got valid/bit=%b, want 11", {out_valid, out_bit});
    end
  endtask

  task automatic test_stuff_removal;
    logic [7:0] seq = 8'b1011_1111;
    logic [7:0] ev  = 8'b1011_1111;
    for (int i = 0; i < 8; i++) begin
      step(seq[i], 1'b1, i == 0);
      n_checks++;
      if (out_valid !== ev[i] || (ev[i] && out_bit !== 1'b1) || stuff_err !== 1'b0) begin
        n_fail++;
        $display("FAIL stuff[%0d]: got valid/bit/err=%b%b%b, want %b1 0", i, out_valid, out_bit, stuff_err, ev[i]);
      end
    end
  endtask

  task automatic test_violation;
    logic [2:0] tail = 3'b010;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, i == 0);
      n_checks++;
      if (i < 6 && {out_valid, out_bit, stuff_err, in_error} !== 4'b1100) begin
        n_fail++;
        $display("FAIL violation_run[%0d]: got valid/bit/err/in_error=%b, want 1100", i, {out_valid, out_bit, stuff_err, in_error});
      end else if (i == 6 && {out_valid, stuff_err, in_error} !== 3'b011) begin
        n_fail++;
        $display("FAIL violation_flag: got valid/err/in_error=%b, want 011", {out_valid, stuff_err, in_error});
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(tail[i], 1'b1, 1'b0);
      n_checks++;
      if ({out_valid, stuff_err, in_error} !== 3'b001) begin
        n_fail++;
        $display("FAIL violation_discard[%0d]: got valid/err/in_error=%b, want 001", i, {out_valid, stuff_err, in_error});
      end
    end
  endtask

  task automatic test_recovery;
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({out_valid, out_bit, in_error} !== 3'b110) begin
      n_fail++;
      $display("FAIL recovery_first: got valid/bit/in_error=%b, want 110", {out_valid, out_bit, in_error});
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({out_valid, out_bit, stuff_err} !== 3'b110) begin
        n_fail++;
        $display("FAIL recovery_run[%0d]: got valid/bit/err=%b, want 110", i, {out_valid, out_bit, stuff_err});
      end
    end
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, stuff_err, in_error} !== 3'b000) begin
      n_fail++;
      $display("FAIL recovery_drop: got valid/err/in_error=%b, want 000", {out_valid, stuff_err, in_error});
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, out_bit} !== 2'b11) begin
      n_fail++;
      $display("FAIL recovery_resume: got valid/bit=%b, want 11", {out_valid, out_bit});
    end
  endtask

  task automatic test_gaps;
    logic [6:0] seq = 7'b011_1111;
    logic [6:0] ev  = 7'b011_1111;
    for (int i = 0; i < 7; i++) begin
      step(seq[i], 1'b1, i == 0);
      n_checks++;
      if (out_valid !== ev[i] || (ev[i] && out_bit !== 1'b1) || stuff_err !== 1'b0) begin
        n_fail++;
        $display("FAIL gaps_bit[%0d]: got valid/bit/err=%b%b%b, want %b1 0", i, out_valid, out_bit, stuff_err, ev[i]);
      end
      for (int g = 0; g < 3; g++) begin
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, stuff_err} !== 2'b00) begin
          n_fail++;
          $display("FAIL gaps_idle[%0d.%0d]: got valid/err=%b, want 00", i, g, {out_valid, stuff_err});
        end
      end
    end
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, out_bit, in_error} !== 3'b100) begin
      n_fail++;
      $display("FAIL gaps_after: got valid/bit/in_error=%b, want 100", {out_valid, out_bit, in_error});
    end
  endtask

  task automatic test_idle_pkt_start;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, i == 0);
    n_checks++;
    if (in_error !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_start_setup: got in_error=%b, want 1", in_error);
    end
    step(1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({in_error, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_start_clear: got in_error/valid=%b, want 00", {in_error, out_valid});
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, stuff_err, in_error} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_start_run: got valid/err/in_error=%b, want 000", {out_valid, stuff_err, in_error});
    end
  endtask

`ifdef USB_UNSTUFF_BYTE_EN
  task automatic test_byte;
    logic [8:0] seq = 9'b1_1011_1111;
    logic [7:0] alt = 8'b1010_1010;
    int pulses = 0;
    logic [7:0] got = 8'h00;
    for (int i = 0; i < 9; i++) begin
      step(seq[i], 1'b1, i == 0);
      if (out_byte_valid) begin pulses++; got = out_byte; end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (out_byte_valid) begin pulses++; got = out_byte; end
    end
    n_checks++;
    if (pulses != 1 || got !== 8'hFF) begin
      n_fail++;
      $display("FAIL byte_ff: got %0d pulses byte=%h, want 1 pulse byte=ff", pulses, got);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, i == 0);
      if (out_byte_valid) pulses++;
    end
    for (int i = 0; i < 8; i++) begin
      step(alt[i], 1'b1, i == 0);
      if (out_byte_valid) begin pulses++; got = out_byte; end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (out_byte_valid) begin pulses++; got = out_byte; end
    end
    n_checks++;
    if (pulses != 1 || got !== 8'hAA) begin
      n_fail++;
      $display("FAIL byte_partial: got %0d pulses byte=%h, want 1 pulse byte=aa", pulses, got);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_stuff_removal;
    test_violation;
    test_recovery;
    test_gaps;
    test_idle_pkt_start;
`ifdef USB_UNSTUFF_BYTE_EN
    test_byte;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_bit_unstuffer.md
Name: usb_bit_unstuffer

Overview:
- Receive-path counterpart of the USB bit stuffer.
- Consumes the NRZI-decoded serial bitstream and removes the zero stuffed after every run of RUN_LEN consecutive ones.
- Flags a stuff error when the bit after a full run is a 1.
- Sits between the NRZI decoder and the packet/PID decoder; one clock domain, one bit per enabled cycle.

Parameters:
- RUN_LEN, 6: consecutive ones after which the transmitter inserts a zero; legal range 2..7.
- CNT_W, 3: width of the internal ones counter; must hold RUN_LEN.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous active-high reset.
- in_bit  input  1  decoded receive bit.
- in_valid  input  1  in_bit is sampled this cycle.
- pkt_start  input  1  one-cycle pulse marking the first bit of a new packet (after SYNC); clears run/error state.
- out_bit  output  1  unstuffed data bit, registered.
- out_valid  output  1  out_bit valid this cycle, registered.
- stuff_err  output  1  one-cycle pulse on a stuffing violation, registered.
- in_error  output  1  level: block is discarding bits until the next pkt_start.

Behaviour:
- Reset (RST high at a clk edge): state=NORMAL, ones_cnt=0; out_bit, out_valid, stuff_err and in_error all 0. Reset mid-packet discards any pending drop.
- Latency: exactly 1 cycle from an accepted in_bit to out_bit/out_valid. No backpressure.
- in_valid low: state and ones_cnt hold; out_valid=0 and stuff_err=0 next cycle.
- States:
  - NORMAL, on a valid bit:
    - out_valid<=1 and out_bit<=in_bit.
    - in_bit=0: ones_cnt<=0.
    - in_bit=1: ones_cnt<=ones_cnt+1.
    - If in_bit=1 and ones_cnt==RUN_LEN-1, go to DROP.
  - DROP, on a valid bit:
    - in_bit=0: stuffed bit is discarded (out_valid<=0); ones_cnt<=0; go to NORMAL.
    - in_bit=1: bit is discarded; stuff_err<=1 for one cycle; go to ERROR.
  - ERROR: every valid bit is discarded (out_valid=0); in_error=1; ones_cnt held at 0. The state is left only via pkt_start or RST.
- pkt_start: ones_cnt and state are treated as 0/NORMAL for the current cycle, from any state.
  - If in_valid is also high, that bit is processed as the first bit of the new packet: it is output, and it counts as 1 towards the run if it is a 1.
  - If pkt_start arrives without in_valid, the state becomes NORMAL and ones_cnt becomes 0.
- stuff_err and out_valid are never both high in the same cycle.
- ones_cnt never exceeds RUN_LEN and does not wrap.
- The bit that completes a run (the RUN_LEN-th one) is always output. Only the following bit is removed.

Optional Feature:
- Macro: USB_UNSTUFF_BYTE_EN.
- When defined, adds the ports out_byte[7:0] and out_byte_valid.
  - Bits with out_valid=1 are shifted in LSB first.
  - out_byte_valid pulses for one cycle, one cycle after the 8th bit's out_valid, together with the completed byte.
  - The bit counter clears on RST, on pkt_start, and when entering ERROR; a partial byte is dropped.
  - Stuffed bits do not advance the bit counter.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- usb_pkg holds:
  - unstuff_state_t enum {NORMAL, DROP, ERROR}.
  - localparam USB_STUFF_RUN=6, shared with the stuffer.
- Sub-module usb_byte_assembler: 8-bit shift register plus 3-bit counter. It is instantiated only under USB_UNSTUFF_BYTE_EN.

Test Plan:
- Reset: hold RST for 2 cycles with in_valid=1 and in_bit=1 -> all outputs 0. The first post-reset bit appears 1 cycle later.
- Stuff removal: pkt_start, then bits 1,1,1,1,1,1,0,1 -> out_valid for 7 bits with output 1,1,1,1,1,1,1. The 0 is dropped (out_valid=0 that cycle) and stuff_err stays 0.
- Violation: pkt_start, then seven 1s -> six bits output, stuff_err pulses on the cycle after the 7th bit, and in_error=1. Subsequent bits 0,1,0 produce no out_valid.
- Recovery: from ERROR, pkt_start with in_valid=1 and in_bit=1 -> in_error=0 and out_bit=1 valid next cycle. Five further 1s then go to DROP, not ERROR.
- Gaps: the run 1,1,1,1,1,1,0 with in_valid low for 3 cycles between every bit -> identical output to the gapless case, and out_valid=0 in gap cycles.
- Byte (USB_UNSTUFF_BYTE_EN): stream 0xFF LSB-first with the stuffed 0 after the 6th one -> out_byte=0xFF with one out_byte_valid pulse; a pkt_start after 3 bits yields no byte.
